// File: rtl/net1_stimulus_seq.sv
// net1_stimulus_seq
//
// Stimulus sequencer for the combinational net1 block. After a start pulse it
// sweeps abcd through 0 .. 2^WIDTH-1. Each value is held for HOLD_CYCLES
// cycles. On the last edge of each hold window it captures net1's xyz
// response into last_xyz.
//
// Optional feature: define NET1_SEQ_CHECKSUM_EN to build an 8-bit running sum
// of the sampled xyz values. Without it, checksum is tied to zero.
//
// Ports
//   clock        system clock, rising edge
//   reset        synchronous, active-high
//   start        begin a sweep (accepted in IDLE and DONE only)
//   pause        freezes the sweep while in DRIVE
//   xyz          net1 response {x, y, z}
//   abcd         driven combination {a, b, c, d}
//   busy         high while sweeping (DRIVE)
//   sample_valid one-cycle pulse when last_xyz has just been updated
//   last_xyz     xyz captured at the end of the latest hold window
//   done         high in DONE until the next start or reset
//   checksum     running sum of sampled xyz modulo 256 (zero if not built)
//
// state  | meaning
// -------+------------------------------------------------
// IDLE   | after reset, waiting for start
// DRIVE  | sweeping abcd, holding each value HOLD_CYCLES
// DONE   | sweep complete, abcd parked at its final value
module net1_stimulus_seq #(
  parameter int WIDTH       = 4,
  parameter int HOLD_CYCLES = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic [2:0]       xyz,
  output logic [WIDTH-1:0] abcd,
  output logic             busy,
  output logic             sample_valid,
  output logic [2:0]       last_xyz,
  output logic             done,
  output logic [7:0]       checksum
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [15:0]      HOLD_RELOAD = 16'(HOLD_CYCLES - 1);
  localparam logic [WIDTH-1:0] ABCD_LAST   = {WIDTH{1'b1}};

  state_t           state_q, state_d;
  logic [15:0]      hold_q, hold_d;
  logic [WIDTH-1:0] abcd_q, abcd_d;
  logic             sv_q, sv_d;
  logic [2:0]       xyz_q, xyz_d;
  logic             sample_edge;
  logic             launch;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      hold_q  <= HOLD_RELOAD;
      abcd_q  <= '0;
      sv_q    <= 1'b0;
      xyz_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      abcd_q  <= abcd_d;
      sv_q    <= sv_d;
      xyz_q   <= xyz_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    abcd_d      = abcd_q;
    sv_d        = 1'b0;
    xyz_d       = xyz_q;
    sample_edge = 1'b0;
    launch      = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_DRIVE;
          hold_d  = HOLD_RELOAD;
          abcd_d  = '0;
          launch  = 1'b1;
        end
      end
      S_DRIVE: begin
        // A paused edge is not a sample edge, even when the counter is at 0.
        if (!pause) begin
          if (hold_q != 16'd0) begin
            hold_d = hold_q - 16'd1;
          end else begin
            sample_edge = 1'b1;
            sv_d        = 1'b1;
            xyz_d       = xyz;
            if (abcd_q == ABCD_LAST) begin
              // abcd stays on the last value; it only wraps through a restart.
              state_d = S_DONE;
            end else begin
              abcd_d = abcd_q + 1'b1;
              hold_d = HOLD_RELOAD;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign abcd         = abcd_q;
  assign busy         = (state_q == S_DRIVE);
  assign done         = (state_q == S_DONE);
  assign sample_valid = sv_q;
  assign last_xyz     = xyz_q;

`ifdef NET1_SEQ_CHECKSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      csum_q <= 8'h00;
    end else if (launch) begin
      csum_q <= 8'h00;
    end else if (sample_edge) begin
      csum_q <= csum_q + {5'b00000, xyz};
    end
  end

  assign checksum = csum_q;
`else
  logic unused_csum_ctrl;
  assign unused_csum_ctrl = launch ^ sample_edge;
  assign checksum         = 8'h00;
`endif

endmodule

// File: tb/tb_net1_stimulus_seq.sv
module tb_net1_stimulus_seq;

  logic       clock;
  logic       reset0, start0, pause0;
  logic [2:0] xyz0;
  logic [3:0] abcd0;
  logic       busy0, sv0, done0;
  logic [2:0] lxyz0;
  logic [7:0] csum0;

  logic       reset1, start1, pause1;
  logic [2:0] xyz1;
  logic [3:0] abcd1;
  logic       busy1, sv1, done1;
  logic [2:0] lxyz1;
  logic [7:0] csum1;

  int checks = 0;
  int errors = 0;
  int drive;
  int svc;

`ifdef NET1_SEQ_CHECKSUM_EN
  localparam logic [7:0] EXP_CSUM_SWEEP = 8'h38;
  localparam logic [7:0] EXP_CSUM_H1    = 8'h50;
`else
  localparam logic [7:0] EXP_CSUM_SWEEP = 8'h00;
  localparam logic [7:0] EXP_CSUM_H1    = 8'h00;
`endif

  // net1 stand-in: response is the low three bits of abcd.
  assign xyz0 = abcd0[2:0];
  assign xyz1 = 3'b101;

  net1_stimulus_seq #(.WIDTH(4), .HOLD_CYCLES(10)) dut0 (
    .clock(clock), .reset(reset0), .start(start0), .pause(pause0), .xyz(xyz0),
    .abcd(abcd0), .busy(busy0), .sample_valid(sv0), .last_xyz(lxyz0),
    .done(done0), .checksum(csum0)
  );

  net1_stimulus_seq #(.WIDTH(4), .HOLD_CYCLES(1)) dut1 (
    .clock(clock), .reset(reset1), .start(start1), .pause(pause1), .xyz(xyz1),
    .abcd(abcd1), .busy(busy1), .sample_valid(sv1), .last_xyz(lxyz1),
    .done(done1), .checksum(csum1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset0 = 1'b1; start0 = 1'b1; pause0 = 1'b0;
    reset1 = 1'b1; start1 = 1'b1; pause1 = 1'b0;

    // Reset dominates start.
    repeat (3) step();
    check("rst_abcd", abcd0, 0);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_sv", sv0, 0);
    check("rst_lxyz", lxyz0, 0);
    check("rst_csum", csum0, 0);
    check("rst1_busy", busy1, 0);
    start0 = 1'b0; start1 = 1'b0;
    reset0 = 1'b0; reset1 = 1'b0;
    step();
    check("idle_busy", busy0, 0);

    // Basic sweep: abcd = drive/10, sample pulse on every 10th cycle.
    start0 = 1'b1; step(); start0 = 1'b0;
    drive = 0; svc = 0;
    while (busy0 && drive < 400) begin
      check("sweep_abcd", abcd0, drive / 10);
      check("sweep_sv", sv0, (drive % 10 == 0 && drive != 0) ? 1 : 0);
      if (sv0) svc++;
      drive++;
      step();
    end
    if (sv0) svc++;
    check("sweep_drive_cycles", drive, 160);
    check("sweep_done", done0, 1);
    check("sweep_final_sv", sv0, 1);
    check("sweep_sv_count", svc, 16);
    check("sweep_last_xyz", lxyz0, 7);
    check("sweep_csum", csum0, EXP_CSUM_SWEEP);
    step();
    check("done_hold_abcd", abcd0, 15);
    check("done_hold_done", done0, 1);
    check("done_sv_low", sv0, 0);
    check("done_csum_hold", csum0, EXP_CSUM_SWEEP);

    // Pause for 7 edges while abcd = 5.
    start0 = 1'b1; step(); start0 = 1'b0;
    check("restart_abcd", abcd0, 0);
    check("restart_done", done0, 0);
    drive = 0;
    while (busy0 && abcd0 != 4'd5 && drive < 200) begin drive++; step(); end
    check("pause_reach", abcd0, 5);
    pause0 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive++;
      step();
      check("pause_abcd", abcd0, 5);
      check("pause_sv", sv0, 0);
    end
    pause0 = 1'b0;
    while (busy0 && drive < 400) begin drive++; step(); end
    check("pause_drive_cycles", drive, 167);
    check("pause_done", done0, 1);
    check("pause_csum", csum0, EXP_CSUM_SWEEP);

    // Pause outside DRIVE does nothing; start mid-sweep is ignored.
    pause0 = 1'b1; step(); pause0 = 1'b0;
    check("pause_in_done", done0, 1);
    start0 = 1'b1; step(); start0 = 1'b0;
    drive = 0;
    while (busy0 && abcd0 != 4'd9 && drive < 200) begin drive++; step(); end
    check("ign_reach", abcd0, 9);
    start0 = 1'b1; drive++; step(); start0 = 1'b0;
    check("ign_abcd", abcd0, 9);
    check("ign_busy", busy0, 1);
    while (busy0 && drive < 400) begin drive++; step(); end
    check("ign_drive_cycles", drive, 160);
    check("ign_final_abcd", abcd0, 15);
    check("ign_done", done0, 1);

    // Start from DONE.
    start0 = 1'b1; step(); start0 = 1'b0;
    check("done_restart_done", done0, 0);
    check("done_restart_abcd", abcd0, 0);
    check("done_restart_busy", busy0, 1);

    // Reset mid-sweep at abcd = 12.
    drive = 0;
    while (busy0 && abcd0 != 4'd12 && drive < 200) begin drive++; step(); end
    check("mrst_reach", abcd0, 12);
    reset0 = 1'b1; step(); reset0 = 1'b0;
    check("mrst_abcd", abcd0, 0);
    check("mrst_busy", busy0, 0);
    check("mrst_done", done0, 0);
    check("mrst_sv", sv0, 0);
    check("mrst_lxyz", lxyz0, 0);
    check("mrst_csum", csum0, 0);
    step();
    check("mrst_stays_idle", busy0, 0);
    start0 = 1'b1; step(); start0 = 1'b0;
    check("mrst_restart_abcd", abcd0, 0);
    check("mrst_restart_busy", busy0, 1);
    drive = 0;
    while (busy0 && drive < 400) begin drive++; step(); end
    check("mrst_drive_cycles", drive, 160);
    check("mrst_csum_final", csum0, EXP_CSUM_SWEEP);

    // HOLD_CYCLES = 1: one value per cycle, sample pulse on 16 consecutive cycles.
    start1 = 1'b1; step(); start1 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("h1_abcd", abcd1, i);
      check("h1_busy", busy1, 1);
      check("h1_sv", sv1, (i != 0) ? 1 : 0);
      step();
    end
    check("h1_busy_end", busy1, 0);
    check("h1_done", done1, 1);
    check("h1_final_sv", sv1, 1);
    check("h1_last_xyz", lxyz1, 5);
    check("h1_csum", csum1, EXP_CSUM_H1);
    step();
    check("h1_sv_drop", sv1, 0);
    check("h1_abcd_hold", abcd1, 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
